// File: rtl/demux1to2_stream.sv
// demux1to2_stream: 1-to-2 valid/ready stream demux, one register per channel.
// Ports: clk, rst_n (async low); In/sel/in_valid/in_ready upstream;
// outN/outN_valid/outN_ready per channel; proto_err sticky; cnt0/cnt1.
// Macro DEMUX_XFER_CNT_EN enables the per-channel transfer counters.
module demux1to2_stream #(
  parameter int DATA_W = 3,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] In,
  input  logic              sel,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out0,
  output logic [DATA_W-1:0] out1,
  output logic              out0_valid,
  output logic              out1_valid,
  input  logic              out0_ready,
  input  logic              out1_ready,
  output logic              proto_err,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1
);

  logic [DATA_W-1:0] data0_q, data0_d;
  logic [DATA_W-1:0] data1_q, data1_d;
  logic              vld0_q, vld0_d;
  logic              vld1_q, vld1_d;
  logic              err_q, err_d;
  logic              stall_q, stall_d;
  logic [DATA_W-1:0] in_q, in_d;
  logic              sel_q, sel_d;
  logic              rdy0, rdy1;
  logic              load0, load1;

  assign rdy0     = !vld0_q || out0_ready;
  assign rdy1     = !vld1_q || out1_ready;
  assign in_ready = sel ? rdy1 : rdy0;
  assign load0    = in_valid && rdy0 && !sel;
  assign load1    = in_valid && rdy1 && sel;

  always_comb begin
    data0_d = data0_q;
    data1_d = data1_q;
    vld0_d  = vld0_q && !out0_ready;
    vld1_d  = vld1_q && !out1_ready;
    if (load0) begin
      data0_d = In;
      vld0_d  = 1'b1;
    end
    if (load1) begin
      data1_d = In;
      vld1_d  = 1'b1;
    end
  end

  // A stalled offer must be held unchanged until it is accepted.
  always_comb begin
    stall_d = in_valid && !in_ready;
    in_d    = In;
    sel_d   = sel;
    err_d   = err_q;
    if (stall_q && (!in_valid || In != in_q || sel != sel_q))
      err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data0_q <= '0;
      data1_q <= '0;
      vld0_q  <= 1'b0;
      vld1_q  <= 1'b0;
      err_q   <= 1'b0;
      stall_q <= 1'b0;
      in_q    <= '0;
      sel_q   <= 1'b0;
    end else begin
      data0_q <= data0_d;
      data1_q <= data1_d;
      vld0_q  <= vld0_d;
      vld1_q  <= vld1_d;
      err_q   <= err_d;
      stall_q <= stall_d;
      in_q    <= in_d;
      sel_q   <= sel_d;
    end
  end

  assign out0       = data0_q;
  assign out1       = data1_q;
  assign out0_valid = vld0_q;
  assign out1_valid = vld1_q;
  assign proto_err  = err_q;

`ifdef DEMUX_XFER_CNT_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  // Counters wrap naturally at 2^CNT_W.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (load0) cnt0_d = cnt0_q + 1'b1;
    if (load1) cnt1_d = cnt1_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`else
  assign cnt0 = '0;
  assign cnt1 = '0;
`endif

endmodule

// File: tb/tb_demux1to2_stream.sv
// tb_demux1to2_stream: directed self-checking bench for demux1to2_stream.
// Drives inputs 1 ns after rising edges and samples there too.
module tb_demux1to2_stream;

  logic       clk;
  logic       rst_n;
  logic [2:0] In;
  logic       sel;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] out0;
  logic [2:0] out1;
  logic       out0_valid;
  logic       out1_valid;
  logic       out0_ready;
  logic       out1_ready;
  logic       proto_err;
  logic [7:0] cnt0;
  logic [7:0] cnt1;

  int errs;
  int checks;

  demux1to2_stream #(.DATA_W(3), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .In         (In),
    .sel        (sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0       (out0),
    .out1       (out1),
    .out0_valid (out0_valid),
    .out1_valid (out1_valid),
    .out0_ready (out0_ready),
    .out1_ready (out1_ready),
    .proto_err  (proto_err),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errs       = 0;
    checks     = 0;
    rst_n      = 1'b0;
    In         = '0;
    sel        = 1'b0;
    in_valid   = 1'b0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    tick();
    tick();
    chk("rst_v0", out0_valid, 0);
    chk("rst_v1", out1_valid, 0);
    chk("rst_err", proto_err, 0);
    chk("rst_o0", out0, 0);
    chk("rst_o1", out1, 0);
    chk("rst_c0", cnt0, 0);
    chk("rst_rdy", in_ready, 1);
    rst_n = 1'b1;

    // Load channel 0 and leave it blocked.
    In = 3'b101; sel = 0; in_valid = 1;
    tick();
    in_valid = 0;
    #1;
    chk("c0_data", out0, 3'b101);
    chk("c0_v0", out0_valid, 1);
    chk("c0_v1", out1_valid, 0);
    chk("c0_rdy", in_ready, 0);

    // Channel 1 still open while channel 0 is full.
    In = 3'b011; sel = 1; in_valid = 1;
    #1;
    chk("c1_rdy", in_ready, 1);
    tick();
    in_valid = 0;
    chk("c1_data", out1, 3'b011);
    chk("c1_v1", out1_valid, 1);
    chk("c1_o0", out0, 3'b101);
    chk("c1_v0", out0_valid, 1);

    // Back-to-back through full channel 1; channel 0 drains meanwhile.
    out1_ready = 1; out0_ready = 1;
    sel = 1; in_valid = 1; In = 3'd1;
    tick();
    out0_ready = 0;
    chk("b2b_1", out1, 1);
    chk("b2b_v1", out1_valid, 1);
    chk("drn_v0", out0_valid, 0);
    In = 3'd2;
    tick();
    chk("b2b_2", out1, 2);
    chk("b2b_v2", out1_valid, 1);
    In = 3'd3;
    tick();
    chk("b2b_3", out1, 3);
    chk("b2b_v3", out1_valid, 1);
    in_valid = 0;
    tick();
    chk("b2b_end", out1_valid, 0);
    out1_ready = 0;
`ifdef DEMUX_XFER_CNT_EN
    chk("cnt0_a", cnt0, 1);
    chk("cnt1_a", cnt1, 4);
`else
    chk("cnt0_a", cnt0, 0);
    chk("cnt1_a", cnt1, 0);
`endif

    // Protocol violation: payload changes while stalled.
    sel = 0; In = 3'd6; in_valid = 1;
    tick();
    chk("pe_fill", out0, 6);
    In = 3'd7;
    #1;
    chk("pe_rdy", in_ready, 0);
    tick();
    chk("pe_hold", proto_err, 0);
    In = 3'd2;
    tick();
    in_valid = 0;
    chk("pe_set", proto_err, 1);
    chk("pe_o0", out0, 6);
    chk("pe_v1", out1_valid, 0);
    tick();
    tick();
    chk("pe_stk", proto_err, 1);
    chk("pe_o0b", out0, 6);

    // Fill channel 1 too, then reset between edges.
    sel = 1; In = 3'd2; in_valid = 1;
    tick();
    in_valid = 0;
    chk("ar_v0", out0_valid, 1);
    chk("ar_v1", out1_valid, 1);
    #2;
    rst_n = 0;
    #1;
    chk("ar_v0z", out0_valid, 0);
    chk("ar_v1z", out1_valid, 0);
    chk("ar_o0z", out0, 0);
    chk("ar_o1z", out1, 0);
    chk("ar_err", proto_err, 0);
    chk("ar_c0", cnt0, 0);
    tick();
    rst_n = 1;

    // 257 accepts to channel 0; first one on first edge after reset.
    sel = 0; out0_ready = 1;
    for (int i = 0; i < 257; i++) begin
      In = 3'(i + 1);
      in_valid = 1;
      tick();
      if (i == 0) begin
        chk("first_v0", out0_valid, 1);
        chk("first_o0", out0, 1);
      end
    end
    in_valid = 0;
    chk("wr_o0", out0, 3'(257));
    chk("wr_err", proto_err, 0);
`ifdef DEMUX_XFER_CNT_EN
    chk("wr_c0", cnt0, 1);
`else
    chk("wr_c0", cnt0, 0);
`endif
    chk("wr_c1", cnt1, 0);
    tick();
    chk("wr_drn", out0_valid, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
